// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider; the requester drives the master side.
interface seq_divider_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// 16-bit restoring shift-subtract divider, one quotient bit per cycle.
// Define SEQ_DIVIDER_SIGNED_DIV_EN for two's-complement signed division (truncating toward zero).
module seq_divider (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   rem_acc, quo_acc, dvs_mag;
  logic [3:0]          iter;
  logic                dvs_zero;
  logic                busy_r, done_r, dbz_r;
  logic [DATA_W-1:0]   quo_r, rem_r;
  logic [DATA_W:0]     shifted, trial;
  logic                q_bit;
  logic [DATA_W-1:0]   res_quo, res_rem;

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  logic q_neg, r_neg;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor != '0) ? CALC : FIN;
      CALC: if (iter == 4'd15) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trial subtraction: bit DATA_W of the 17-bit difference is the borrow.
  always_comb begin
    shifted = {rem_acc, quo_acc[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_mag};
    q_bit   = ~trial[DATA_W];
  end

  // After a zero-divisor latch quo_acc still holds the dividend magnitude.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    res_quo = apply_sign(quo_acc, q_neg);
    res_rem = dvs_zero ? apply_sign(quo_acc, r_neg) : apply_sign(rem_acc, r_neg);
`else
    res_quo = quo_acc;
    res_rem = dvs_zero ? quo_acc : rem_acc;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_acc  <= '0;
      quo_acc  <= '0;
      dvs_mag  <= '0;
      iter     <= '0;
      dvs_zero <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      quo_r    <= '0;
      rem_r    <= '0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r   <= 1'b1;
            rem_acc  <= '0;
            iter     <= '0;
            dvs_zero <= (bus.divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            quo_acc  <= magnitude(bus.dividend);
            dvs_mag  <= magnitude(bus.divisor);
            q_neg    <= bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1];
            r_neg    <= bus.dividend[DATA_W-1];
`else
            quo_acc  <= bus.dividend;
            dvs_mag  <= bus.divisor;
`endif
          end
        end
        CALC: begin
          rem_acc <= q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
          quo_acc <= {quo_acc[DATA_W-2:0], q_bit};
          iter    <= iter + 4'd1;
        end
        FIN: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          dbz_r  <= dvs_zero;
          quo_r  <= dvs_zero ? {DATA_W{1'b1}} : res_quo;
          rem_r  <= res_rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: timestamp-based reference model checked every cycle plus directed literal cases.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;

  seq_divider_if bus ();

  seq_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference result {div_by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q, r;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    int ai, bi;
`endif
    if (b == 16'd0) return {1'b1, 16'hFFFF, a};
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    ai = int'($signed(a));
    bi = int'($signed(b));
    q  = 16'(ai / bi);
    r  = 16'(ai % bi);
`else
    q = a / b;
    r = a % b;
`endif
    return {1'b0, q, r};
  endfunction

  logic [32:0] mres, held = '0;
  int          edge_n = 0, due = 0;
  logic        pending = 1'b0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_z = 1'b0;
  logic [15:0] exp_q = '0, exp_r = '0;

  always_comb mres = model(bus.dividend, bus.divisor);

  // Accept when no job is pending; a job finishes 17 edges after acceptance (1 for a zero divisor).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_z    <= 1'b0;
      exp_q    <= '0;
      exp_r    <= '0;
      edge_n   <= 0;
      due      <= 0;
    end else begin
      edge_n   <= edge_n + 1;
      exp_done <= 1'b0;
      if (pending) begin
        if (edge_n + 1 == due) begin
          {exp_z, exp_q, exp_r} <= held;
          exp_done <= 1'b1;
          exp_busy <= 1'b0;
          pending  <= 1'b0;
        end
      end else if (bus.start) begin
        held     <= mres;
        due      <= edge_n + 1 + ((bus.divisor == 16'd0) ? 1 : 17);
        pending  <= 1'b1;
        exp_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(bus.busy), 32'(exp_busy));
      chk("cyc_done", 32'(bus.done), 32'(exp_done));
      chk("cyc_quotient", 32'(bus.quotient), 32'(exp_q));
      chk("cyc_remainder", 32'(bus.remainder), 32'(exp_r));
      chk("cyc_dbz", 32'(bus.div_by_zero), 32'(exp_z));
    end
  end

  // Called at a negedge; drives start there so it is sampled on the next edge T.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic ez,
                         input int elat, input int inject);
    int n;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    n = 0;
    while (!bus.done && n < 40) begin
      if (inject != 0 && n == inject) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(elat));
    chk({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_quotient", 32'(bus.quotient), 32'd0);
    chk("reset_remainder", 32'(bus.remainder), 32'd0);
    chk("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 0);
    @(negedge clk);
    run_div("d1234_0", 16'd1234, 16'd0, 16'hFFFF, 16'h04D2, 1'b1, 1, 0);
    run_div("d10_3", 16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 17, 0);
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    run_div("neg100_7", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, 17, 0);
    run_div("min_neg1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, 0);
`else
    run_div("ff9c_7", 16'hFF9C, 16'd7, 16'h2484, 16'h0000, 1'b0, 17, 0);
    run_div("8000_ffff", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17, 0);
`endif
    repeat (2) @(negedge clk);
    run_div("ignore_start", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 4);
    repeat (3) @(negedge clk);
    run_div("b2b_first", 16'd5000, 16'd250, 16'd20, 16'd0, 1'b0, 17, 0);
    run_div("b2b_second", 16'd7, 16'd9, 16'd0, 16'd7, 1'b0, 17, 0);
    run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 17, 0);

    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    chk("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_div("after_rst", 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 17, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have no parameters; datapath width is fixed at 16 bits.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  16  numerator; MSB is sign bit when signed.
REQ-006 SHALL have port: divisor  input  16  denominator; MSB is sign bit when signed.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when results are valid.
REQ-009 SHALL have port: quotient  output  16  registered quotient.
REQ-010 SHALL have port: remainder  output  16  registered remainder.
REQ-011 SHALL have port: div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 SHALL use a restoring shift-subtract algorithm: one quotient bit per cycle, MSB first, 16 iterations on operand magnitudes.
REQ-013 SHALL have FSM states IDLE, CALC and FIN.
- IDLE->CALC on start with divisor nonzero.
- CALC->FIN after the 16th iteration.
- FIN->IDLE unconditionally.
REQ-014 SHALL latch both operands on the edge T where start is sampled; later input changes SHALL NOT affect the result.
REQ-015 SHALL perform each iteration as a left shift of {partial_remainder, quotient_bits}, a 17-bit trial subtraction of the divisor magnitude, and a commit with quotient bit 1 when the trial is non-negative, else a restore with bit 0.
REQ-016 SHALL timestamp a normal division as follows:
- busy high from edge T to edge T+17.
- Iterations on edges T+1 through T+16.
- On edge T+17: quotient, remainder and div_by_zero are updated, done rises, busy falls.
- done falls on edge T+18.
REQ-017 SHALL ignore start while busy is high.
REQ-018 SHALL accept start sampled while done is high, since the FSM is then in IDLE; the next division then begins back-to-back.
REQ-019 SHALL skip CALC when the latched divisor is 0, and on edge T+1 SHALL update outputs as follows:
- done=1, busy=0.
- quotient=16'hFFFF.
- remainder=dividend.
- div_by_zero=1.
REQ-020 SHALL clear div_by_zero on every non-zero-divisor completion.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable between done pulses.
REQ-022 SHALL wrap results modulo 2^16 with no overflow flag.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force:
- FSM to IDLE.
- busy=0, done=0, div_by_zero=0.
- quotient=16'h0000, remainder=16'h0000.
- All internal registers to 0.
REQ-024 SHALL abandon any in-progress division when reset is asserted, with no done pulse, and SHALL accept a new start on the first edge after rst_n deasserts.

Configuration
REQ-025 SHALL support macro SEQ_DIVIDER_SIGNED_DIV_EN as the single compile-time option.
REQ-026 SHALL, with SEQ_DIVIDER_SIGNED_DIV_EN defined, apply two's-complement signed semantics:
- Operands are converted to magnitudes at latch.
- Quotient is negated iff operand signs differ.
- Remainder takes the dividend's sign, so results truncate toward zero.
- -32768 / -1 yields quotient 16'h8000, remainder 0, per REQ-022.
REQ-027 SHALL, with SEQ_DIVIDER_SIGNED_DIV_EN undefined, treat operands as unsigned, omit the sign logic entirely, and keep identical latency.

Verification
REQ-028 SHALL cover: start with 100/7 at edge T -> done only on edge T+17, quotient=14, remainder=2, div_by_zero=0, busy high T..T+17.
REQ-029 SHALL cover: 1234/0 -> done on edge T+1, quotient=16'hFFFF, remainder=16'h04D2, div_by_zero=1; then 10/3 -> quotient=3, remainder=1, div_by_zero=0.
REQ-030 SHALL cover, signed build:
- 0xFF9C/7 (-100/7) -> quotient=16'hFFF2, remainder=16'hFFFE.
- 0x8000/0xFFFF -> quotient=16'h8000, remainder=0.
REQ-031 SHALL cover, unsigned build: 0xFF9C/7 -> quotient=16'h2484, remainder=0.
REQ-032 SHALL cover: start pulsed again at T+5 with different operands -> ignored, first result unchanged; start while done is high -> second result done exactly 17 edges later.
REQ-033 SHALL cover: rst_n low at T+8 -> busy, done and outputs 0 immediately, no done pulse follows; start after release gives a correct result 17 edges later.
